// File: rtl/soc_design_gpio_pkg.sv
// Shared constants for the GPIO PIO family: register word indices and edge-capture modes.
// Latency: none (constants only).
// Backpressure: none.
package soc_design_gpio_pkg;

    // Register word indices on the Avalon-MM slave
    localparam logic [2:0] GPIO_DATA     = 3'd0;
    localparam logic [2:0] GPIO_DIR      = 3'd1;
    localparam logic [2:0] GPIO_IRQ_MASK = 3'd2;
    localparam logic [2:0] GPIO_EDGE_CAP = 3'd3;
    localparam logic [2:0] GPIO_OUTSET   = 3'd4;
    localparam logic [2:0] GPIO_OUTCLR   = 3'd5;

    // Edge-capture modes
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_design_gpio_pio_if.sv
// Avalon-MM slave bus bundle for one GPIO bank (word-addressed, 32-bit data).
// Latency: readdata is registered by the slave, valid one cycle after the read strobe.
// Backpressure: none, no wait states.
interface soc_design_gpio_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_design_gpio_sync.sv
// Two-flop pin synchroniser plus previous-value flop and per-bit edge detector.
// Latency: pin sampled at edge k appears on o_in_sync after edge k+1; o_edge is combinational from it.
// Backpressure: none, free-running every cycle.
module soc_design_gpio_sync
    import soc_design_gpio_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_gpio_in,
    output logic [WIDTH-1:0] o_in_sync,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    // Synchroniser chain; r_prev starts at 0 so a pin high out of reset reads as a rising edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_gpio_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Edge vector selected by the elaboration-time capture mode
    always_comb begin
        o_edge = r_sync & ~r_prev;
        case (EDGE_TYPE)
            EDGE_FALL: o_edge = ~r_sync & r_prev;
            EDGE_ANY:  o_edge = r_sync ^ r_prev;
            default:   o_edge = r_sync & ~r_prev;
        endcase
    end

    assign o_in_sync = r_sync;

endmodule

// File: rtl/soc_design_gpio_pio.sv
// Parametrised GPIO bank: data/dir registers, atomic set/clear, edge capture and masked level irq.
// Latency: writes land at the sampling edge; readdata one cycle after the read strobe; pin-to-irq 3 edges.
// Backpressure: none, every access completes in one cycle.
module soc_design_gpio_pio
    import soc_design_gpio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1,
    parameter logic [WIDTH-1:0] RESET_DIR   = '1,
    parameter int               EDGE_TYPE   = EDGE_RISE
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    soc_design_gpio_pio_if.slave        bus,
    input  logic [WIDTH-1:0]            i_gpio_in,
    output logic [WIDTH-1:0]            o_gpio_out,
    output logic [WIDTH-1:0]            o_gpio_oe,
    output logic                        o_irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_wdat;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_in_sync;
    logic [WIDTH-1:0] w_edge;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign w_wr   = bus.chipselect && !bus.write_n;
    assign w_rd   = bus.chipselect && bus.read;
    assign w_wdat = bus.writedata[WIDTH-1:0];
    assign w_clr  = (w_wr && (bus.address == GPIO_EDGE_CAP)) ? w_wdat : '0;

    // Upper writedata bits are deliberately ignored for narrow banks
    assign w_unused = &{1'b0, bus.writedata};

    soc_design_gpio_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_gpio_in (i_gpio_in),
        .o_in_sync (w_in_sync),
        .o_edge    (w_edge)
    );

    // Software-visible control registers; reset overrides a concurrent write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= RESET_DIR;
            r_irq_mask <= '0;
        end else if (w_wr) begin
            case (bus.address)
                GPIO_DATA:     r_data_out <= w_wdat;
                GPIO_DIR:      r_dir      <= w_wdat;
                GPIO_IRQ_MASK: r_irq_mask <= w_wdat;
                GPIO_OUTSET:   r_data_out <= r_data_out | w_wdat;
                GPIO_OUTCLR:   r_data_out <= r_data_out & ~w_wdat;
                default:       ;
            endcase
        end
    end

    // Edge capture with W1C; a new edge on the same bit beats the clear
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
        end
    end

    // Level interrupt registered from the current capture state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge_cap & r_irq_mask);
        end
    end

    // Read mux from pre-write register state, so read-during-write returns the old value
    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            GPIO_DATA:     w_rd_mux[WIDTH-1:0] = (w_in_sync & ~r_dir) | (r_data_out & r_dir);
            GPIO_DIR:      w_rd_mux[WIDTH-1:0] = r_dir;
            GPIO_IRQ_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            GPIO_EDGE_CAP: w_rd_mux[WIDTH-1:0] = r_edge_cap;
            default:       w_rd_mux = '0;
        endcase
    end

    // Read data register holds until the next read strobe
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign o_gpio_out   = r_data_out;
    assign o_gpio_oe    = r_dir;
    assign o_irq        = r_irq;

endmodule

// File: tb/tb_soc_design_gpio_pio.sv
// Directed bench for the GPIO bank: register map, set/clear, input read, edge/irq timing, reset override.
// Latency: checks sampled on the falling edge after each rising edge of interest.
// Backpressure: none.
module tb_soc_design_gpio_pio;
    import soc_design_gpio_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pins, pins2;
    logic [W-1:0] gout, goe, gout2, goe2;
    logic         irq, irq2;
    logic [31:0]  rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    soc_design_gpio_pio_if bus ();
    soc_design_gpio_pio_if bus2 ();

    soc_design_gpio_pio #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE)) u_dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .bus        (bus),
        .i_gpio_in  (pins),
        .o_gpio_out (gout),
        .o_gpio_oe  (goe),
        .o_irq      (irq)
    );

    soc_design_gpio_pio #(.WIDTH(W), .EDGE_TYPE(EDGE_ANY)) u_dut_any (
        .i_clk      (clk),
        .i_reset    (rst),
        .bus        (bus2),
        .i_gpio_in  (pins2),
        .o_gpio_out (gout2),
        .o_gpio_oe  (goe2),
        .o_irq      (irq2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_bus(input bit sel, input logic cs, input logic rdn, input logic wn,
                             input logic [2:0] a, input logic [31:0] d);
        if (sel) begin
            bus2.chipselect = cs; bus2.read = rdn; bus2.write_n = wn;
            bus2.address = a; bus2.writedata = d;
        end else begin
            bus.chipselect = cs; bus.read = rdn; bus.write_n = wn;
            bus.address = a; bus.writedata = d;
        end
    endtask

    task automatic bus_write(input bit sel, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_bus(sel, 1'b1, 1'b0, 1'b0, a, d);
        @(negedge clk);
        drive_bus(sel, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    task automatic bus_read(input bit sel, input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        drive_bus(sel, 1'b1, 1'b1, 1'b1, a, 32'd0);
        @(negedge clk);
        drive_bus(sel, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
        d = sel ? bus2.readdata : bus.readdata;
    endtask

    initial begin
        rst   = 1'b1;
        pins  = '0;
        pins2 = '0;
        drive_bus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
        drive_bus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst_gpio_out", 32'(gout), 32'h0000_00FF);
        check_eq("rst_gpio_oe",  32'(goe),  32'h0000_00FF);
        check_eq("rst_irq",      32'(irq),  32'h0);
        check_eq("rst_readdata", bus.readdata, 32'h0);
        bus_read(1'b0, GPIO_DATA, rd);
        check_eq("rst_read_data", rd, 32'h0000_00FF);

        // Data write, atomic set and clear
        bus_write(1'b0, GPIO_DATA, 32'h0000_000F);
        check_eq("wr_data", 32'(gout), 32'h0F);
        bus_write(1'b0, GPIO_OUTSET, 32'h0000_0030);
        check_eq("outset", 32'(gout), 32'h3F);
        bus_write(1'b0, GPIO_OUTCLR, 32'h0000_0001);
        check_eq("outclr", 32'(gout), 32'h3E);
        bus_write(1'b0, GPIO_OUTSET, 32'hFFFF_FF00);
        check_eq("outset_upper_ignored", 32'(gout), 32'h3E);
        bus_read(1'b0, GPIO_OUTSET, rd);
        check_eq("rd_outset", rd, 32'h0);
        bus_read(1'b0, GPIO_DIR, rd);
        check_eq("rd_dir", rd, 32'h0000_00FF);
        bus_read(1'b0, GPIO_OUTCLR, rd);
        check_eq("rd_outclr", rd, 32'h0);
        bus_read(1'b0, 3'd6, rd);
        check_eq("rd_reserved", rd, 32'h0);
        bus_read(1'b0, GPIO_DIR, rd);
        repeat (2) @(negedge clk);
        check_eq("readdata_hold", bus.readdata, 32'h0000_00FF);

        // Mixed direction read
        bus_write(1'b0, GPIO_DIR, 32'h0000_00F0);
        check_eq("gpio_oe", 32'(goe), 32'hF0);
        pins = 8'hA5;
        repeat (4) @(negedge clk);
        bus_read(1'b0, GPIO_DATA, rd);
        check_eq("rd_data_mixed", rd, 32'h0000_0035);
        bus_read(1'b0, GPIO_EDGE_CAP, rd);
        check_eq("rd_edge_cap_rise", rd, 32'h0000_00A5);
        check_eq("irq_masked_off", 32'(irq), 32'h0);
        bus_write(1'b0, GPIO_EDGE_CAP, 32'h0000_00FF);
        bus_read(1'b0, GPIO_EDGE_CAP, rd);
        check_eq("edge_cap_w1c", rd, 32'h0);

        // Falling edge ignored in rising mode
        pins = 8'hA4;
        repeat (4) @(negedge clk);
        bus_read(1'b0, GPIO_EDGE_CAP, rd);
        check_eq("fall_ignored", rd, 32'h0);
        bus_write(1'b0, GPIO_IRQ_MASK, 32'h0000_0001);
        bus_read(1'b0, GPIO_IRQ_MASK, rd);
        check_eq("rd_irq_mask", rd, 32'h0000_0001);

        // Pin-to-irq timing: sampled at edge k, capture at k+2, irq at k+3
        @(negedge clk);
        pins = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        check_eq("cap_at_k",   32'(u_dut.r_edge_cap), 32'h0);
        @(negedge clk);
        check_eq("cap_at_k1",  32'(u_dut.r_edge_cap), 32'h0);
        @(negedge clk);
        check_eq("cap_at_k2",  32'(u_dut.r_edge_cap), 32'h01);
        check_eq("irq_at_k2",  32'(irq), 32'h0);
        @(negedge clk);
        check_eq("irq_at_k3",  32'(irq), 32'h1);
        bus_write(1'b0, GPIO_EDGE_CAP, 32'h0000_0001);
        check_eq("w1c_cap",    32'(u_dut.r_edge_cap), 32'h0);
        check_eq("w1c_irq_k",  32'(irq), 32'h1);
        @(negedge clk);
        check_eq("w1c_irq_k1", 32'(irq), 32'h0);

        // Any-edge instance: falling edge captured in the same cycle as a W1C keeps the bit
        bus_write(1'b1, GPIO_IRQ_MASK, 32'h0000_0001);
        @(negedge clk);
        pins2 = 8'h01;
        repeat (4) @(negedge clk);
        check_eq("any_rise_irq", 32'(irq2), 32'h1);
        pins2 = 8'h00;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        drive_bus(1'b1, 1'b1, 1'b0, 1'b0, GPIO_EDGE_CAP, 32'h0000_0001);
        @(posedge clk);
        @(negedge clk);
        drive_bus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
        check_eq("set_beats_clr_cap", 32'(u_dut_any.r_edge_cap), 32'h01);
        check_eq("set_beats_clr_irq", 32'(irq2), 32'h1);
        @(negedge clk);
        check_eq("set_beats_clr_irq2", 32'(irq2), 32'h1);
        bus_write(1'b1, GPIO_EDGE_CAP, 32'h0000_0001);
        @(negedge clk);
        check_eq("any_clr_cap", 32'(u_dut_any.r_edge_cap), 32'h0);
        check_eq("any_clr_irq", 32'(irq2), 32'h0);

        // Reset overriding a concurrent DATA write
        pins = 8'hA4;
        repeat (4) @(negedge clk);
        pins = 8'hA5;
        repeat (4) @(negedge clk);
        check_eq("pre_reset_irq", 32'(irq), 32'h1);
        rst = 1'b1;
        drive_bus(1'b0, 1'b1, 1'b0, 1'b0, GPIO_DATA, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_bus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
        check_eq("rst_wr_gpio_out", 32'(gout), 32'h0000_00FF);
        check_eq("rst_wr_gpio_oe",  32'(goe),  32'h0000_00FF);
        check_eq("rst_wr_cap",      32'(u_dut.r_edge_cap), 32'h0);
        check_eq("rst_wr_irq",      32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_design_gpio_pio.md
# soc_design_gpio_pio

Parametrised Avalon-MM general-purpose I/O port: the successor to the fixed 32-bit output-only LED PIO. It adds a per-bit direction register, a synchronised input path, atomic bit set/clear, edge capture and a maskable level interrupt. It sits on the HPS lightweight bridge as an `e_avalon_slave`, one instance per GPIO bank (LEDs, keys, switches).

## Interface
- `WIDTH`, 32, number of GPIO bits (1..32); unused `readdata` bits read 0.
- `RESET_VALUE`, all ones, reset value of the output data register (`data_out`).
- `RESET_DIR`, all ones, reset value of the direction register (1 = output).
- `EDGE_TYPE`, 0, capture mode: 0 = rising, 1 = falling, 2 = any edge.
- `clk`  in  1  single system clock; every register is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  word register index.
- `chipselect`  in  1  slave select.
- `read`  in  1  read strobe, qualified by `chipselect`.
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `gpio_in`  in  WIDTH  asynchronous pin inputs.
- `gpio_out`  out  WIDTH  output data; equals `data_out`.
- `gpio_oe`  out  WIDTH  output enables; equals `dir`.
- `irq`  out  1  registered level interrupt.

## Operation
- Register map (word index):
  - 0 DATA: write loads `data_out`. Read returns `in_sync` on input bits and `data_out` on output bits.
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns captured edges; writing 1 to a bit clears it.
  - 4 OUTSET: write ORs `writedata` into `data_out`; reads 0.
  - 5 OUTCLR: write ANDs `~writedata` into `data_out`; reads 0.
  - 6–7: reserved; writes ignored, reads 0.
- Write strobe: `chipselect && !write_n`. Read strobe: `chipselect && read`.
- Input path:
  - `gpio_in` passes through a 2-flop synchroniser to give `in_sync`.
  - A third flop holds `in_prev`.
  - Edge is `in_sync & ~in_prev` (rising), `~in_sync & in_prev` (falling), or `in_sync ^ in_prev` (any).
- Edge capture:
  - Edges are captured on all bits regardless of DIR.
  - `EDGE_CAP[i]` is set by an edge and cleared by a W1C write.
  - If an edge and a clear hit the same bit in the same cycle, the set wins.
- Interrupt: `irq <= |(EDGE_CAP & IRQ_MASK)`, registered.
- Reset values:
  - `data_out` = `RESET_VALUE`, `dir` = `RESET_DIR`.
  - IRQ_MASK, EDGE_CAP, `readdata` and `irq` = 0.
  - Synchroniser flops = 0, and `in_prev` = 0. The first post-reset cycle with a pin at 1 therefore counts as a rising edge; software clears EDGE_CAP after enabling.
- Reset asserted mid-operation overrides any concurrent write in the same cycle.
- Only bits [WIDTH-1:0] of `writedata` are used; upper bits are ignored.

## Timing
- Writes take effect at the clock edge that samples the strobe. `gpio_out`/`gpio_oe` change in the next cycle.
- Read latency is 1:
  - `readdata` is valid in the cycle after the read strobe and holds until the next read.
  - A read and a write to the same register in the same cycle return the old value.
- No wait states; no `waitrequest`.
- Pin-to-interrupt path, with the pin change sampled at edge k:
  - `in_sync` at k+1;
  - EDGE_CAP bit at k+2;
  - `irq` at k+3.
- A W1C write at edge k drops `irq` at edge k+1, provided no new edge is captured.

## Structure
- Shared package `soc_design_gpio_pkg`:
  - address constants `GPIO_DATA`…`GPIO_OUTCLR`;
  - edge-type constants `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
- Sub-module `soc_design_gpio_sync`: parameter `WIDTH`, `EDGE_TYPE`. It contains the 2-flop synchroniser, `in_prev` and the edge vector, and is reused by the future input-only key PIO.
- Top level holds the register file, read mux, readdata register and irq register.

## Test plan
- Reset, WIDTH=8, default params → `gpio_out`=0xFF, `gpio_oe`=0xFF, `irq`=0. A read of DATA returns 0x000000FF one cycle after the strobe.
- Write DATA=0x0F, then OUTSET=0x30, then OUTCLR=0x01 → `gpio_out` 0x0F→0x3F→0x3E, each one cycle after its write. Reads of OUTSET/OUTCLR return 0.
- DIR=0xF0, pins=0xA5 held ≥3 cycles → DATA read = 0xA5 for the low nibble and `data_out` for the high nibble, i.e. 0x3_5 with `data_out`=0x3E → 0x35.
- EDGE_TYPE=0, IRQ_MASK=0x01, rising edge on pin 0 sampled at edge k:
  - EDGE_CAP=0x01 at k+2 and `irq`=1 at k+3.
  - W1C write 0x01 clears `irq` one cycle later.
- Falling edge on pin 0 coincides with a W1C of bit 0 (EDGE_TYPE=2) → bit stays set and `irq` stays 1.
- Assert `reset` in the same cycle as a DATA write of 0x00 → `gpio_out`=`RESET_VALUE`; EDGE_CAP=0, `irq`=0 the next cycle.
